// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the ball-state I2C receiver: receive FSM
// states, the target address, frame length and the payload layout.
// No ports (package).
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0]  I2C_BALL_ADDR    = 7'h55;
    localparam int unsigned BALL_FRAME_BYTES = 3;
    localparam logic        I2C_WRITE_BIT    = 1'b0;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned SHIFT_W    = BYTE_W - 1;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned BYTE_CNT_W = 2;
    localparam int unsigned BALL_Y_W   = 10;
    localparam int unsigned BALL_VY_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } rx_state_t;

    // Committed ball state as presented to the game logic
    typedef struct packed {
        logic [BALL_Y_W-1:0]  y;
        logic [BALL_VY_W-1:0] vy;
    } ball_frame_t;

    // True when an address byte selects this target for a write
    function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                        input logic [6:0]        slv_addr);
        return (addr_byte[BYTE_W-1:1] == slv_addr) && (addr_byte[0] == I2C_WRITE_BIT);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings SCL/SDA into the clk domain and derives bus-level strobes. No
// protocol knowledge lives here.
//   clk, reset      : system clock, synchronous active-high reset
//   i_scl, i_sda    : raw asynchronous bus lines
//   o_sda           : synchronized SDA level (registered)
//   o_scl_rise_c    : SCL rising edge strobe
//   o_scl_fall_c    : SCL falling edge strobe
//   o_start_c       : SDA fell while SCL high
//   o_stop_c        : SDA rose while SCL high
// A pin change shows up on the strobes two clocks later, so logic that
// registers a strobe acts on it on the third clock.
// ---------------------------------------------------------------------------
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise_c,
    output logic o_scl_fall_c,
    output logic o_start_c,
    output logic o_stop_c
);

    logic r_scl_meta;
    logic r_scl_sync;
    logic r_scl_prev;
    logic r_sda_meta;
    logic r_sda_sync;
    logic r_sda_prev;

    // Two-flop synchronizers plus one history flop; reset to the idle-bus level
    // so leaving reset never fabricates a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign o_sda        = r_sda_sync;
    assign o_scl_rise_c =  r_scl_sync & ~r_scl_prev;
    assign o_scl_fall_c = ~r_scl_sync &  r_scl_prev;
    // SCL must be high on both samples so a simultaneous SCL/SDA move is not a condition
    assign o_start_c    = r_scl_sync & r_scl_prev &  r_sda_prev & ~r_sda_sync;
    assign o_stop_c     = r_scl_sync & r_scl_prev & ~r_sda_prev &  r_sda_sync;

endmodule

// File: rtl/i2c_ball_receiver.sv
// ---------------------------------------------------------------------------
// i2c_ball_receiver
// Write-only I2C target that receives {y[9:8],6'bx}, y[7:0], vy frames and
// commits them atomically on STOP. No clock stretching, reads are ignored.
//   SLV_ADDR   : 7-bit target address
//   clk, reset : system clock, synchronous active-high reset
//   scl        : I2C clock line (asynchronous)
//   sda_in     : I2C data line as seen at the pad (asynchronous)
//   sda_oe     : 1 pulls SDA low (ACK)
//   ball_y     : last committed Y coordinate
//   ball_vy    : last committed Y velocity
//   ball_valid : one-cycle pulse on commit
//   frame_err  : one-cycle pulse on a malformed addressed frame
//   busy       : high from an address match until STOP or START
// ---------------------------------------------------------------------------
module i2c_ball_receiver
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = I2C_BALL_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [BALL_Y_W-1:0]  ball_y,
    output logic [BALL_VY_W-1:0] ball_vy,
    output logic                 ball_valid,
    output logic                 frame_err,
    output logic                 busy
);

    // Synchronized line events
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_line_sync u_line_sync (
        .clk          (clk),
        .reset        (reset),
        .i_scl        (scl),
        .i_sda        (sda_in),
        .o_sda        (w_sda),
        .o_scl_rise_c (w_scl_rise),
        .o_scl_fall_c (w_scl_fall),
        .o_start_c    (w_start),
        .o_stop_c     (w_stop)
    );

    // State and datapath registers with their next values
    rx_state_t              r_state,       w_state_nxt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt,     w_bit_cnt_nxt;
    logic [BYTE_CNT_W-1:0]  r_byte_cnt,    w_byte_cnt_nxt;
    logic [SHIFT_W-1:0]     r_shift,       w_shift_nxt;
    logic [1:0]             r_byte0_hi,    w_byte0_hi_nxt;   // byte0[5:0] carries nothing
    logic [BYTE_W-1:0]      r_byte1,       w_byte1_nxt;
    logic [BYTE_W-1:0]      r_byte2,       w_byte2_nxt;
    logic                   r_addressed,   w_addressed_nxt;
    logic                   r_overflow,    w_overflow_nxt;
    logic                   r_ack_on,      w_ack_on_nxt;
    logic                   r_sda_oe,      w_sda_oe_nxt;
    ball_frame_t            r_ball,        w_ball_nxt;
    logic                   r_ball_valid,  w_ball_valid_nxt;
    logic                   r_frame_err,   w_frame_err_nxt;
    logic                   r_busy,        w_busy_nxt;

    // Byte as it stands once the current bit is shifted in
    logic [BYTE_W-1:0] w_shift_in;
    logic              w_last_bit;

    assign w_shift_in = {r_shift, w_sda};
    assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1));

    // Register update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_byte0_hi   <= '0;
            r_byte1      <= '0;
            r_byte2      <= '0;
            r_addressed  <= 1'b0;
            r_overflow   <= 1'b0;
            r_ack_on     <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_ball       <= '0;
            r_ball_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_byte0_hi   <= w_byte0_hi_nxt;
            r_byte1      <= w_byte1_nxt;
            r_byte2      <= w_byte2_nxt;
            r_addressed  <= w_addressed_nxt;
            r_overflow   <= w_overflow_nxt;
            r_ack_on     <= w_ack_on_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_ball       <= w_ball_nxt;
            r_ball_valid <= w_ball_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and output logic; bus conditions take priority over bit sampling
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_shift_nxt      = r_shift;
        w_byte0_hi_nxt   = r_byte0_hi;
        w_byte1_nxt      = r_byte1;
        w_byte2_nxt      = r_byte2;
        w_addressed_nxt  = r_addressed;
        w_overflow_nxt   = r_overflow;
        w_ack_on_nxt     = r_ack_on;
        w_sda_oe_nxt     = r_sda_oe;
        w_ball_nxt       = r_ball;
        w_ball_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_busy_nxt       = r_busy;

        if (w_start) begin
            // (Repeated) START: drop any partial frame and listen for an address
            w_state_nxt     = ST_ADDR;
            w_bit_cnt_nxt   = '0;
            w_byte_cnt_nxt  = '0;
            w_addressed_nxt = 1'b0;
            w_overflow_nxt  = 1'b0;
            w_ack_on_nxt    = 1'b0;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
            w_frame_err_nxt = r_addressed && (r_byte_cnt != '0);
        end else if (w_stop) begin
            w_state_nxt     = ST_IDLE;
            w_bit_cnt_nxt   = '0;
            w_byte_cnt_nxt  = '0;
            w_addressed_nxt = 1'b0;
            w_overflow_nxt  = 1'b0;
            w_ack_on_nxt    = 1'b0;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
            if (r_addressed) begin
                if ((r_byte_cnt == BYTE_CNT_W'(BALL_FRAME_BYTES)) && !r_overflow) begin
                    w_ball_nxt.y     = {r_byte0_hi, r_byte1};
                    w_ball_nxt.vy    = r_byte2;
                    w_ball_valid_nxt = 1'b1;
                end else begin
                    w_frame_err_nxt = 1'b1;
                end
            end
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in[SHIFT_W-1:0];
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            if (addr_match(w_shift_in, SLV_ADDR)) begin
                                w_state_nxt     = ST_ADDR_ACK;
                                w_addressed_nxt = 1'b1;
                                w_busy_nxt      = 1'b1;
                            end else begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end
                    end
                end

                // First SCL fall after the 8th bit pulls SDA, the next one releases it
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_ack_on_nxt = 1'b1;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_ack_on_nxt = 1'b0;
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in[SHIFT_W-1:0];
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            if (r_byte_cnt == BYTE_CNT_W'(BALL_FRAME_BYTES)) begin
                                // Extra byte: NACK it and poison the frame
                                w_overflow_nxt = 1'b1;
                                w_state_nxt    = ST_IGNORE;
                            end else begin
                                case (r_byte_cnt)
                                    BYTE_CNT_W'(0): w_byte0_hi_nxt = w_shift_in[BYTE_W-1:BYTE_W-2];
                                    BYTE_CNT_W'(1): w_byte1_nxt    = w_shift_in;
                                    default:        w_byte2_nxt    = w_shift_in;
                                endcase
                                w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                                w_state_nxt    = ST_DATA_ACK;
                            end
                        end
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign ball_y     = r_ball.y;
    assign ball_vy    = r_ball.vy;
    assign ball_valid = r_ball_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_ball_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2c_ball_receiver
// Drives write frames as an I2C controller and checks ACKs, pulses and the
// committed ball state against hand-written vectors and a frame-level model.
// ---------------------------------------------------------------------------
module tb_i2c_ball_receiver;
    import i2c_pkg::*;

    localparam int HALF  = 10;   // SCL high/low phase in clk cycles
    localparam int SETUP = 5;    // SDA change delay after SCL falls

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_ctl = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic       ball_valid;
    logic       frame_err;
    logic       busy;

    assign sda_in = sda_ctl & ~sda_oe;   // open-drain wired AND

    i2c_ball_receiver #(.SLV_ADDR(7'h55)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .ball_y     (ball_y),
        .ball_vy    (ball_vy),
        .ball_valid (ball_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_busy = 0;

    // Running counts of pulses and busy cycles
    always @(negedge clk) begin
        if (ball_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1)  n_err++;
        if (busy === 1'b1)       n_busy++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run did not finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0][7:0] fb;
        int              n;
        logic [5:0]      ack;
        int              v;
        int              e;
        logic            bz;
        logic [9:0]      y;
        logic [7:0]      vy;
    } vec_t;

    vec_t       tbl [6];
    logic       oe_bad;
    logic [9:0] m_y;
    logic [7:0] m_vy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, input int n,
                                input logic [5:0] ack, input int v, e, input logic bz,
                                input logic [9:0] y, input logic [7:0] vy);
        vec_t t;
        t.fb = '0;
        t.fb[0] = b0; t.fb[1] = b1; t.fb[2] = b2; t.fb[3] = b3; t.fb[4] = b4;
        t.n = n; t.ack = ack; t.v = v; t.e = e; t.bz = bz; t.y = y; t.vy = vy;
        return t;
    endfunction

    task automatic bus_start();
        sda_ctl = 1'b0; cyc(HALF);
        scl = 1'b0;
    endtask

    task automatic bus_rstart();
        cyc(SETUP); sda_ctl = 1'b1;
        cyc(SETUP); scl = 1'b1;
        cyc(HALF);  sda_ctl = 1'b0;
        cyc(HALF);  scl = 1'b0;
    endtask

    task automatic bus_stop();
        cyc(SETUP); sda_ctl = 1'b0;
        cyc(SETUP); scl = 1'b1;
        cyc(HALF);  sda_ctl = 1'b1;
        cyc(HALF);
    endtask

    // Eight data bits; the target must never pull SDA while they are clocked
    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cyc(SETUP); sda_ctl = b[i];
            cyc(SETUP); scl = 1'b1;
            cyc(HALF / 2);
            if (sda_oe !== 1'b0) oe_bad = 1'b1;
            cyc(HALF / 2); scl = 1'b0;
        end
    endtask

    task automatic ack_slot(output logic ack);
        cyc(SETUP); sda_ctl = 1'b1;
        cyc(SETUP); scl = 1'b1;
        cyc(HALF / 2); ack = (sda_oe === 1'b1) && (sda_in === 1'b0);
        cyc(HALF / 2); scl = 1'b0;
    endtask

    task automatic send_bytes(input logic [5:0][7:0] fb, input int n, output logic [5:0] ack);
        logic a;
        ack = '0;
        for (int i = 0; i < n; i++) begin
            send_bits(fb[i]);
            ack_slot(a);
            ack[i] = a;
        end
    endtask

    task automatic run_frame(input logic [5:0][7:0] fb, input int n, output logic [5:0] ack,
                             output int dv, output int de, output int db);
        int v0, e0, b0;
        v0 = n_valid; e0 = n_err; b0 = n_busy;
        oe_bad = 1'b0;
        bus_start();
        send_bytes(fb, n, ack);
        bus_stop();
        cyc(4);
        dv = n_valid - v0; de = n_err - e0; db = n_busy - b0;
    endtask

    task automatic check_frame(input string tag, input logic [5:0] ack, input int dv, de, db,
                               input logic [5:0] e_ack, input int e_v, e_e, input logic e_bz,
                               input logic [9:0] e_y, input logic [7:0] e_vy);
        chk({tag, "_ack"},       32'(ack),    32'(e_ack));
        chk({tag, "_oe_stray"},  32'(oe_bad), 32'(0));
        chk({tag, "_valid"},     32'(dv),     32'(e_v));
        chk({tag, "_err"},       32'(de),     32'(e_e));
        chk({tag, "_busy_seen"}, 32'(db > 0), 32'(e_bz));
        chk({tag, "_ball_y"},    32'(ball_y), 32'(e_y));
        chk({tag, "_ball_vy"},   32'(ball_vy), 32'(e_vy));
        chk({tag, "_busy_end"},  32'(busy),   32'(0));
        chk({tag, "_oe_end"},    32'(sda_oe), 32'(0));
    endtask

    // Frame-level reference: address hits ACK up to three data bytes, and a
    // STOP after exactly three data bytes commits; any other addressed frame is an error.
    task automatic model_frame(input logic [5:0][7:0] fb, input int n, output logic [5:0] e_ack,
                               output int e_v, output int e_e, output logic e_bz);
        logic hit;
        hit = (fb[0] == 8'hAA);
        e_ack = '0; e_v = 0; e_e = 0; e_bz = hit;
        for (int i = 0; i < n; i++)
            if (hit && i <= int'(BALL_FRAME_BYTES)) e_ack[i] = 1'b1;
        if (hit) begin
            if (n - 1 == int'(BALL_FRAME_BYTES)) begin
                m_y  = {fb[1][7:6], fb[2]};
                m_vy = fb[3];
                e_v  = 1;
            end else begin
                e_e = 1;
            end
        end
    endtask

    logic [5:0] r_ack;
    int         r_dv, r_de, r_db;

    initial begin
        logic a;
        int   v0, e0;

        tbl[0] = mk(8'hAA, 8'h80, 8'h2C, 8'h05, 8'h00, 4, 6'b001111, 1, 0, 1'b1, 10'h22C, 8'h05);
        tbl[1] = mk(8'hA8, 8'h11, 8'h22, 8'h33, 8'h00, 4, 6'b000000, 0, 0, 1'b0, 10'h22C, 8'h05);
        tbl[2] = mk(8'hAB, 8'h12, 8'h34, 8'h56, 8'h00, 4, 6'b000000, 0, 0, 1'b0, 10'h22C, 8'h05);
        tbl[3] = mk(8'hAA, 8'h40, 8'h10, 8'h00, 8'h00, 3, 6'b000111, 0, 1, 1'b1, 10'h22C, 8'h05);
        tbl[4] = mk(8'hAA, 8'hC0, 8'hFF, 8'h7F, 8'h01, 5, 6'b001111, 0, 1, 1'b1, 10'h22C, 8'h05);
        tbl[5] = mk(8'hAA, 8'hC0, 8'h12, 8'h80, 8'h00, 4, 6'b001111, 1, 0, 1'b1, 10'h312, 8'h80);

        // Reset state
        cyc(3); reset = 1'b0; cyc(2);
        chk("rst_sda_oe",     32'(sda_oe),     32'(0));
        chk("rst_ball_y",     32'(ball_y),     32'(0));
        chk("rst_ball_vy",    32'(ball_vy),    32'(0));
        chk("rst_ball_valid", 32'(ball_valid), 32'(0));
        chk("rst_frame_err",  32'(frame_err),  32'(0));
        chk("rst_busy",       32'(busy),       32'(0));

        // Vector table
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].fb, tbl[i].n, r_ack, r_dv, r_de, r_db);
            check_frame($sformatf("vec%0d", i), r_ack, r_dv, r_de, r_db, tbl[i].ack,
                        tbl[i].v, tbl[i].e, tbl[i].bz, tbl[i].y, tbl[i].vy);
        end

        // Repeated START: empty addressed frame is silent, one with data is an error
        v0 = n_valid; e0 = n_err; oe_bad = 1'b0;
        bus_start();
        send_bits(8'hAA); ack_slot(a);
        chk("rs_addr1_ack", 32'(a), 32'(1));
        bus_rstart();
        chk("rs_busy_clr", 32'(busy), 32'(0));
        chk("rs_no_err0", 32'(n_err - e0), 32'(0));
        send_bits(8'hAA); ack_slot(a);
        send_bits(8'h7F); ack_slot(a);
        chk("rs_byte_ack", 32'(a), 32'(1));
        bus_rstart();
        chk("rs_err1", 32'(n_err - e0), 32'(1));
        send_bits(8'hAA); ack_slot(a);
        send_bits(8'h40); ack_slot(a);
        send_bits(8'h2C); ack_slot(a);
        send_bits(8'h05); ack_slot(a);
        chk("rs_last_ack", 32'(a), 32'(1));
        bus_stop(); cyc(4);
        chk("rs_valid", 32'(n_valid - v0), 32'(1));
        chk("rs_err_total", 32'(n_err - e0), 32'(1));
        chk("rs_ball_y", 32'(ball_y), 32'(10'h12C));
        chk("rs_ball_vy", 32'(ball_vy), 32'(8'h05));

        // Reset during byte1's ACK slot
        v0 = n_valid; e0 = n_err;
        bus_start();
        send_bits(8'hAA); ack_slot(a);
        send_bits(8'h80); ack_slot(a);
        send_bits(8'h2C);
        cyc(SETUP); sda_ctl = 1'b1;
        chk("rstb_pre_oe", 32'(sda_oe), 32'(1));
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("rstb_sda_oe",  32'(sda_oe),  32'(0));
        chk("rstb_ball_y",  32'(ball_y),  32'(0));
        chk("rstb_ball_vy", 32'(ball_vy), 32'(0));
        chk("rstb_busy",    32'(busy),    32'(0));
        cyc(SETUP - 1); scl = 1'b1;
        cyc(HALF); scl = 1'b0;
        bus_stop(); cyc(4);
        chk("rstb_no_pulse", 32'((n_valid - v0) + (n_err - e0)), 32'(0));
        r_ack = '0;
        begin
            logic [5:0][7:0] fb;
            fb = '0; fb[0] = 8'hAA; fb[1] = 8'h00; fb[2] = 8'h64; fb[3] = 8'hFE;
            run_frame(fb, 4, r_ack, r_dv, r_de, r_db);
        end
        check_frame("post_rst", r_ack, r_dv, r_de, r_db, 6'b001111, 1, 0, 1'b1, 10'd100, 8'hFE);

        // Randomized frames against the frame-level model
        m_y = 10'd100; m_vy = 8'hFE;
        for (int k = 0; k < 12; k++) begin
            logic [5:0][7:0] fb;
            logic [5:0]      e_ack;
            int              e_v, e_e, nd, sel;
            logic            e_bz;
            fb  = '0;
            sel = int'($urandom_range(0, 3));
            fb[0] = (sel < 2) ? 8'hAA : (sel == 2) ? 8'hAB : 8'($urandom);
            nd = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 4));
            for (int j = 1; j <= nd; j++) fb[j] = 8'($urandom);
            model_frame(fb, nd + 1, e_ack, e_v, e_e, e_bz);
            run_frame(fb, nd + 1, r_ack, r_dv, r_de, r_db);
            check_frame($sformatf("rnd%0d", k), r_ack, r_dv, r_de, r_db, e_ack, e_v, e_e, e_bz,
                        m_y, m_vy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
